divider_8: RTL and testbench
============================

Name: divider_8

Overview:
- Sequential 8-bit unsigned restoring divider for the lab3 switch/button datapath; the inverse of the existing shift-add multiplier.
- The dividend is loaded from SW into the quotient/dividend register Q.
- Run latches the divisor from SW and performs 8 shift/trial-subtract iterations.
- Quotient and remainder are driven to LEDs/HEX through the existing HexDriver.

Parameters:
- WIDTH, 8, operand width. Only 8 is required to work; the counter width is derived as clog2(WIDTH)+1.

Ports:
- Clk  input  1  system clock, rising edge
- Reset  input  1  asynchronous, active-high; clears all state
- Load_Clear  input  1  sync, active-high; in IDLE: Q<=SW, R<=0, DivZero<=0
- Run  input  1  sync, active-high level; starts a division
- SW  input  8  dividend (on Load_Clear) / divisor (latched in START)
- Qval  output  8  quotient/dividend register Q
- Rval  output  8  remainder R[7:0]
- Rsign  output  1  R[8], trial-subtract sign bit; 0 at rest
- Busy  output  1  high in START/SHIFT/SUB
- Done  output  1  high in DONE
- DivZero  output  1  latched divisor==0 flag for the current result
- HEX0, HEX1  output  7 each  Q[3:0], Q[7:4] via HexDriver
- HEX2, HEX3  output  7 each  R[3:0], R[7:4] via HexDriver

Behaviour:
- Registers:
  - R: 9-bit partial remainder.
  - Q: 8-bit.
  - D: 8-bit latched divisor.
  - cnt: iteration counter.
  - state: IDLE, START, SHIFT, SUB, DONE.
- Reset (any time, including mid-operation): state=IDLE, R=0, Q=0, D=0, cnt=0, Busy=Done=DivZero=0. HEX then shows 0000.
- IDLE:
  - Load_Clear=1: load Q, clear R and DivZero; stay IDLE. Load_Clear has priority over Run in the same cycle.
  - Run=1 with Load_Clear=0: go to START.
- START (1 cycle): D<=SW, R<=0, cnt<=0, DivZero<=(SW==0); go to SHIFT.
- SHIFT: {R,Q}<={R[7:0],Q,1'b0} (9-bit R receives Q[7]); go to SUB.
- SUB: compute t=R-{1'b0,D} (9-bit).
  - If t[8]==0: R<=t, Q[0]<=1.
  - Else: R unchanged (restore), Q[0]<=0.
  - Then cnt<=cnt+1; go to SHIFT if cnt+1<8, else DONE.
- DONE:
  - Hold results; Done=1.
  - Stay while Run=1. No restart on a held Run; one division per Run press.
  - Run=0: go to IDLE with results retained (Done drops).
- Load_Clear is ignored outside IDLE. Run is ignored in START/SHIFT/SUB.
- SW changes after START do not affect the running division (D is latched).
- Latency: with the edge that samples Run=1 in IDLE counted as edge 1, Done=1 after edge 18 (1 START + 8×2 iterations + 1). Busy=1 from after edge 1 through edge 17.
- Arithmetic invariants at DONE: Rsign=0, R<D (when D≠0), and Q*D+R equals the dividend.
- Divide by zero: no special path. The algorithm naturally yields Q=0xFF, R=dividend; DivZero=1.
- Back-to-back: the next division operates on the current Q (previous quotient) unless Load_Clear is used in IDLE.
- All outputs are registered state or pure decode of it; HEX outputs are combinational from Q/R.

Test Plan:
- Reset; Load_Clear with SW=0x64; Run with SW=0x07 -> Done after 18 edges; Qval=0x0E, Rval=0x02, DivZero=0; HEX3..0="020E".
- Load 0xFF; Run with divisor 0x01 -> Q=0xFF, R=0x00. Then load 0x05; Run with divisor 0x09 -> Q=0x00, R=0x05.
- Load 0x2A; Run with divisor 0x00 -> Q=0xFF, R=0x2A, DivZero=1. A following Load_Clear -> DivZero=0.
- Hold Run high for 40 cycles after Done -> no second division; Done stays 1. Release Run -> IDLE with Q/R retained. Press Run again -> divides the retained Q (0x0E/0x07 -> Q=0x02, R=0x00).
- Assert Reset at edge 9 of a division -> all outputs 0 immediately (asynchronous), state IDLE. Load_Clear and Run pulsed together in IDLE -> only the load occurs.
- Change SW every cycle during Busy -> result matches the divisor sampled in START; Load_Clear pulses during Busy are ignored.

Source files
------------

// File: rtl/divider_8.sv
// ---------------------------------------------------------------------------
// divider_8
//
// Sequential unsigned restoring divider for the lab3 switch/button datapath.
// It is the inverse of the shift-add multiplier and uses the same
// operating model:
//   * Load_Clear in IDLE puts the dividend from SW into Q and clears R.
//   * Run starts a division. The divisor is taken from SW in the START cycle.
//     The divider then does WIDTH shift / trial-subtract iterations.
//   * When it finishes, Q holds the quotient and R holds the remainder.
//
// Ports
//   Clk        in   system clock, rising edge
//   Reset      in   asynchronous active-high reset, clears all state
//   Load_Clear in   IDLE only: Q <= SW, R <= 0, DivZero <= 0
//   Run        in   level; starts one division per press
//   SW         in   dividend (Load_Clear) / divisor (sampled in START)
//   Qval       out  quotient / dividend register Q
//   Rval       out  remainder R[WIDTH-1:0]
//   Rsign      out  R[WIDTH], sign of the trial subtraction (0 at rest)
//   Busy       out  high in START / SHIFT / SUB
//   Done       out  high in DONE
//   DivZero    out  divisor of the current result was zero
//   HEX0..HEX3 out  active-low seven-segment digits for Q[3:0], Q[7:4],
//                   R[3:0] and R[7:4]
//
// Timing: the edge that samples Run in IDLE is edge 1. START takes one
// cycle, and each of the 8 iterations takes two cycles (SHIFT then SUB).
// Done is therefore high after edge 18.
//
// The HEX decode reads the low 8 bits of Q and R. Only WIDTH = 8 is
// supported.
// ---------------------------------------------------------------------------
module divider_8 #(
    parameter int WIDTH = 8
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Load_Clear,
    input  logic             Run,
    input  logic [WIDTH-1:0] SW,
    output logic [WIDTH-1:0] Qval,
    output logic [WIDTH-1:0] Rval,
    output logic             Rsign,
    output logic             Busy,
    output logic             Done,
    output logic             DivZero,
    output logic [6:0]       HEX0,
    output logic [6:0]       HEX1,
    output logic [6:0]       HEX2,
    output logic [6:0]       HEX3
);

    // One extra bit so the counter can hold the value WIDTH itself.
    localparam int CNT_W = $clog2(WIDTH) + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_SHIFT,
        S_SUB,
        S_DONE
    } state_t;

    // -----------------------------------------------------------------------
    // Seven-segment decode, active low, segment order {g,f,e,d,c,b,a}.
    // This matches the lab's HexDriver.
    // -----------------------------------------------------------------------
    function automatic logic [6:0] hex_driver(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0: seg = 7'b1000000;
            4'h1: seg = 7'b1111001;
            4'h2: seg = 7'b0100100;
            4'h3: seg = 7'b0110000;
            4'h4: seg = 7'b0011001;
            4'h5: seg = 7'b0010010;
            4'h6: seg = 7'b0000010;
            4'h7: seg = 7'b1111000;
            4'h8: seg = 7'b0000000;
            4'h9: seg = 7'b0010000;
            4'hA: seg = 7'b0001000;
            4'hB: seg = 7'b0000011;
            4'hC: seg = 7'b1000110;
            4'hD: seg = 7'b0100001;
            4'hE: seg = 7'b0000110;
            default: seg = 7'b0001110;   // 4'hF
        endcase
        return seg;
    endfunction

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    state_t             state_q, state_d;
    logic [WIDTH:0]     R_q, R_d;        // partial remainder incl. sign bit
    logic [WIDTH-1:0]   Q_q, Q_d;        // dividend, turning into quotient
    logic [WIDTH-1:0]   D_q, D_d;        // latched divisor
    logic [CNT_W-1:0]   cnt_q, cnt_d;    // completed iterations
    logic               dz_q, dz_d;      // divide-by-zero flag

    logic [WIDTH:0]     trial;           // R - D, its MSB says "does not fit"
    logic [CNT_W-1:0]   cnt_inc;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= S_IDLE;
            R_q     <= '0;
            Q_q     <= '0;
            D_q     <= '0;
            cnt_q   <= '0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            R_q     <= R_d;
            Q_q     <= Q_d;
            D_q     <= D_d;
            cnt_q   <= cnt_d;
            dz_q    <= dz_d;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state and datapath
    // -----------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        R_d     = R_q;
        Q_d     = Q_q;
        D_d     = D_q;
        cnt_d   = cnt_q;
        dz_d    = dz_q;

        trial   = R_q - {1'b0, D_q};
        cnt_inc = cnt_q + CNT_W'(1);

        case (state_q)
            S_IDLE: begin
                // Load wins over Run when both are pressed in the same cycle.
                if (Load_Clear) begin
                    Q_d  = SW;
                    R_d  = '0;
                    dz_d = 1'b0;
                end else if (Run) begin
                    state_d = S_START;
                end
            end

            S_START: begin
                D_d     = SW;
                R_d     = '0;
                cnt_d   = '0;
                dz_d    = (SW == '0);
                state_d = S_SHIFT;
            end

            S_SHIFT: begin
                // Shift {R,Q} left as one register. Q's MSB moves into R, and
                // Q[0] is left free for the next quotient bit.
                {R_d, Q_d} = {R_q[WIDTH-1:0], Q_q, 1'b0};
                state_d    = S_SUB;
            end

            S_SUB: begin
                // Restoring step. Commit the subtraction only if the result
                // is non-negative; otherwise keep R unchanged.
                if (!trial[WIDTH]) begin
                    R_d    = trial;
                    Q_d[0] = 1'b1;
                end else begin
                    Q_d[0] = 1'b0;
                end
                cnt_d   = cnt_inc;
                state_d = (cnt_inc < CNT_W'(WIDTH)) ? S_SHIFT : S_DONE;
            end

            S_DONE: begin
                // Hold here while Run stays high. A held button must not
                // start a second division.
                if (!Run) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Outputs: registered state or a pure decode of it.
    // -----------------------------------------------------------------------
    assign Qval    = Q_q;
    assign Rval    = R_q[WIDTH-1:0];
    assign Rsign   = R_q[WIDTH];
    assign Busy    = (state_q == S_START) || (state_q == S_SHIFT) ||
                     (state_q == S_SUB);
    assign Done    = (state_q == S_DONE);
    assign DivZero = dz_q;

    // Nibble sources: 0..1 = Q low/high, 2..3 = R low/high.
    logic [3:0] hex_nib [4];
    logic [6:0] hex_seg [4];

    assign hex_nib[0] = Q_q[3:0];
    assign hex_nib[1] = Q_q[7:4];
    assign hex_nib[2] = R_q[3:0];
    assign hex_nib[3] = R_q[7:4];

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_hex
            assign hex_seg[gi] = hex_driver(hex_nib[gi]);
        end
    endgenerate

    assign HEX0 = hex_seg[0];
    assign HEX1 = hex_seg[1];
    assign HEX2 = hex_seg[2];
    assign HEX3 = hex_seg[3];

endmodule

// File: tb/tb_divider_8.sv
// ---------------------------------------------------------------------------
// tb_divider_8
//
// Bench for divider_8, driven by directed vectors with hand-computed results.
// Each division pushes its expected quotient, remainder, DivZero flag and
// start edge into a queue. A monitor pops one entry whenever Done rises and
// compares the outputs, the seven-segment digits and the latency.
// The stimulus process also makes direct checks: reset state, hold
// behaviour, returning to IDLE, asynchronous reset, and load priority.
// ---------------------------------------------------------------------------
module tb_divider_8;

    logic       Clk = 1'b0;
    logic       Reset;
    logic       Load_Clear;
    logic       Run;
    logic [7:0] SW;
    logic [7:0] Qval;
    logic [7:0] Rval;
    logic       Rsign;
    logic       Busy;
    logic       Done;
    logic       DivZero;
    logic [6:0] HEX0, HEX1, HEX2, HEX3;

    divider_8 #(.WIDTH(8)) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .Load_Clear (Load_Clear),
        .Run        (Run),
        .SW         (SW),
        .Qval       (Qval),
        .Rval       (Rval),
        .Rsign      (Rsign),
        .Busy       (Busy),
        .Done       (Done),
        .DivZero    (DivZero),
        .HEX0       (HEX0),
        .HEX1       (HEX1),
        .HEX2       (HEX2),
        .HEX3       (HEX3)
    );

    always #5 Clk = ~Clk;

    int n_checks = 0;
    int n_fail   = 0;
    int edge_cnt = 0;

    always @(posedge Clk) edge_cnt++;

    typedef struct {
        string      name;
        logic [7:0] q;
        logic [7:0] r;
        logic       dz;
        int         start_edge;
    } exp_t;

    exp_t sb[$];

    // Reference seven-segment patterns, active low, {g,f,e,d,c,b,a}.
    function automatic logic [6:0] seg_ref(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0: s = 7'h40;  4'h1: s = 7'h79;  4'h2: s = 7'h24;  4'h3: s = 7'h30;
            4'h4: s = 7'h19;  4'h5: s = 7'h12;  4'h6: s = 7'h02;  4'h7: s = 7'h78;
            4'h8: s = 7'h00;  4'h9: s = 7'h10;  4'hA: s = 7'h08;  4'hB: s = 7'h03;
            4'hC: s = 7'h46;  4'hD: s = 7'h21;  4'hE: s = 7'h06;  default: s = 7'h0E;
        endcase
        return s;
    endfunction

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------------------------------------------------------------
    // Monitor: pops one expected result on each rising edge of Done.
    // ---------------------------------------------------------------------
    logic done_prev = 1'b0;

    always @(negedge Clk) begin
        exp_t e;
        if (Done === 1'b1 && done_prev !== 1'b1) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_done: Done rose with no division pending (Q=0x%0h R=0x%0h)",
                         Qval, Rval);
            end else begin
                e = sb.pop_front();
                check({e.name, "_q"},       Qval,     e.q);
                check({e.name, "_r"},       Rval,     e.r);
                check({e.name, "_rsign"},   Rsign,    1'b0);
                check({e.name, "_divzero"}, DivZero,  e.dz);
                check({e.name, "_latency"}, edge_cnt, e.start_edge + 17);
                check({e.name, "_hex"}, {HEX3, HEX2, HEX1, HEX0},
                      {seg_ref(e.r[7:4]), seg_ref(e.r[3:0]),
                       seg_ref(e.q[7:4]), seg_ref(e.q[3:0])});
                $display("txn %s: Q=0x%02h R=0x%02h DivZero=%0b at edge %0d",
                         e.name, Qval, Rval, DivZero, edge_cnt);
            end
        end
        done_prev = Done;
    end

    // ---------------------------------------------------------------------
    // Stimulus helpers
    // ---------------------------------------------------------------------
    task automatic load(input logic [7:0] v);
        SW         = v;
        Load_Clear = 1'b1;
        @(negedge Clk);
        Load_Clear = 1'b0;
    endtask

    // Runs one division. If scramble is set, SW is randomised and Load_Clear
    // is pulsed randomly after the divisor has been sampled. Run is held for
    // `hold` cycles after Done, then released.
    task automatic divide(input string name, input logic [7:0] d,
                          input logic [7:0] eq, input logic [7:0] er,
                          input logic edz, input bit scramble, input int hold);
        exp_t e;
        int   i;
        bit   saw_busy;
        bit   done_dropped;
        e.name       = name;
        e.q          = eq;
        e.r          = er;
        e.dz         = edz;
        e.start_edge = edge_cnt + 1;
        sb.push_back(e);

        SW  = d;
        Run = 1'b1;
        @(negedge Clk);                    // edge 1 taken: START
        check({name, "_busy_start"}, Busy, 1'b1);
        @(negedge Clk);                    // edge 2 taken: divisor latched
        i = 0;
        while (Done !== 1'b1 && i < 40) begin
            if (scramble) begin
                SW         = 8'($urandom);
                Load_Clear = 1'($urandom_range(0, 1));
            end
            @(negedge Clk);
            i++;
        end
        Load_Clear = 1'b0;
        if (Done !== 1'b1) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s_timeout: Done=%0b, expected 1 within budget", name, Done);
        end

        saw_busy     = 1'b0;
        done_dropped = 1'b0;
        for (int k = 0; k < hold; k++) begin
            @(negedge Clk);
            if (Busy !== 1'b0) saw_busy = 1'b1;
            if (Done !== 1'b1) done_dropped = 1'b1;
        end
        if (hold > 0) begin
            check({name, "_hold_no_restart"}, saw_busy, 1'b0);
            check({name, "_hold_done"},       done_dropped, 1'b0);
            check({name, "_hold_q"},          Qval, eq);
        end

        Run = 1'b0;
        @(negedge Clk);                    // back to IDLE
        check({name, "_idle_done"}, Done, 1'b0);
        check({name, "_idle_busy"}, Busy, 1'b0);
        check({name, "_keep_q"},    Qval, eq);
        check({name, "_keep_r"},    Rval, er);
    endtask

    // ---------------------------------------------------------------------
    // Main sequence
    // ---------------------------------------------------------------------
    initial begin
        Reset      = 1'b1;
        Load_Clear = 1'b0;
        Run        = 1'b0;
        SW         = 8'h00;
        repeat (2) @(negedge Clk);
        check("rst_q",       Qval,    8'h00);
        check("rst_r",       Rval,    8'h00);
        check("rst_busy",    Busy,    1'b0);
        check("rst_done",    Done,    1'b0);
        check("rst_divzero", DivZero, 1'b0);
        check("rst_hex", {HEX3, HEX2, HEX1, HEX0}, {7'h40, 7'h40, 7'h40, 7'h40});
        Reset = 1'b0;
        @(negedge Clk);

        // 100 / 7 = 14 r 2. Run is held 40 cycles past Done.
        load(8'h64);
        check("load_q", Qval, 8'h64);
        divide("d100_7", 8'h07, 8'h0E, 8'h02, 1'b0, 1'b0, 40);

        // Back-to-back without a load: 14 / 7 = 2 r 0.
        divide("d14_7", 8'h07, 8'h02, 8'h00, 1'b0, 1'b0, 0);

        // 255 / 1 and 5 / 9.
        load(8'hFF);
        divide("d255_1", 8'h01, 8'hFF, 8'h00, 1'b0, 1'b0, 0);
        load(8'h05);
        divide("d5_9", 8'h09, 8'h00, 8'h05, 1'b0, 1'b0, 0);

        // Divide by zero, then clear the flag with a load.
        load(8'h2A);
        divide("d42_0", 8'h00, 8'hFF, 8'h2A, 1'b1, 1'b0, 0);
        load(8'h10);
        check("clr_divzero", DivZero, 1'b0);
        check("clr_q",       Qval,    8'h10);
        check("clr_r",       Rval,    8'h00);

        // 200 / 13 = 15 r 5. SW and Load_Clear are scrambled while busy.
        load(8'hC8);
        divide("d200_13_scr", 8'h0D, 8'h0F, 8'h05, 1'b0, 1'b1, 0);

        // Asynchronous reset in the middle of a division.
        load(8'h64);
        SW  = 8'h07;
        Run = 1'b1;
        repeat (8) @(negedge Clk);
        check("mid_busy", Busy, 1'b1);
        @(posedge Clk);                    // edge 9
        #1 Reset = 1'b1;
        #1;
        check("arst_q",       Qval,    8'h00);
        check("arst_r",       Rval,    8'h00);
        check("arst_busy",    Busy,    1'b0);
        check("arst_done",    Done,    1'b0);
        check("arst_divzero", DivZero, 1'b0);
        check("arst_hex", {HEX3, HEX2, HEX1, HEX0}, {7'h40, 7'h40, 7'h40, 7'h40});
        Run = 1'b0;
        @(negedge Clk);
        Reset = 1'b0;
        @(negedge Clk);
        check("arst_idle", Busy, 1'b0);

        // Load_Clear and Run together in IDLE: only the load happens.
        SW         = 8'h33;
        Load_Clear = 1'b1;
        Run        = 1'b1;
        @(negedge Clk);
        Load_Clear = 1'b0;
        Run        = 1'b0;
        check("prio_busy", Busy, 1'b0);
        check("prio_q",    Qval, 8'h33);
        @(negedge Clk);
        check("prio_still_idle", Busy, 1'b0);

        // 51 / 5 = 10 r 1.
        divide("d51_5", 8'h05, 8'h0A, 8'h01, 1'b0, 1'b0, 0);

        repeat (3) @(negedge Clk);
        check("sb_empty", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule
